ifu: RTL

IFU -- requirements
Module: ifu

---
 rtl/ifu_pkg.sv | 21 ++
 rtl/ifu_npc.sv | 28 ++
 rtl/ifu.sv | 102 ++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared definitions for the instruction fetch unit.
//   state_e  : fetch/issue FSM encoding
//   PC_STEP  : sequential PC increment in bytes
//   OP_*     : MIPS primary opcode values seen in the opcode field
package ifu_pkg;

   typedef enum logic {
      FETCH = 1'b0,
      ISSUE = 1'b1
   } state_e;

   localparam logic [31:0] PC_STEP  = 32'd4;

   localparam logic [5:0]  OP_RTYPE = 6'h00;
   localparam logic [5:0]  OP_BEQ   = 6'h04;
   localparam logic [5:0]  OP_ORI   = 6'h0d;
   localparam logic [5:0]  OP_LUI   = 6'h0f;
   localparam logic [5:0]  OP_LW    = 6'h23;
   localparam logic [5:0]  OP_SW    = 6'h2b;

endpackage

// File: rtl/ifu_npc.sv
// npc: combinational next-PC calculation.
//   pc      in  : address of the instruction being retired
//   imm16   in  : branch offset in words (signed)
//   nPC_sel in  : instruction is a branch
//   zero    in  : ALU zero flag; branch is taken only when set
//   next_pc out : pc + 4, or pc + 4 + (sext(imm16) << 2) for a taken branch
// All arithmetic is 32-bit and wraps silently.
module npc
   import ifu_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [15:0] imm16,
   input  logic        nPC_sel,
   input  logic        zero,
   output logic [31:0] next_pc
);

   logic [31:0] offset;

   always_comb begin
      offset = '0;
      if (nPC_sel && zero) begin
         offset = {{14{imm16[15]}}, imm16, 2'b00};
      end
      next_pc = pc + PC_STEP + offset;
   end

endmodule

// File: rtl/ifu.sv
// ifu: two-state instruction fetch unit.
//   FETCH: imem_req high with imem_addr = pc until imem_ack; imem_rdata is
//          captured into the instruction register on the ack cycle.
//   ISSUE: instr_valid high, instruction register frozen until exec_done;
//          then pc advances via npc and retired increments.
// Handshake: a fetch completes in any cycle where imem_req && imem_ack (ack may
// arrive in the very cycle req rises); an issue completes in any cycle where
// instr_valid && exec_done. imem_ack outside FETCH and exec_done outside ISSUE
// are ignored.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   imem_req/addr/ack/rdata : instruction memory interface
//   nPC_sel, zero, exec_done : branch control and completion from datapath
//   instr_valid, instr, opcode/funct/rs/rt/rd/imm16 : issued instruction
//   pc, retired           : current instruction address, retire count
//   dbg_state_o           : current FSM state
module ifu
   import ifu_pkg::*;
#(
   parameter logic [31:0] PC_RESET = 32'h0000_3000
)(
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        nPC_sel,
   input  logic        zero,
   input  logic        exec_done,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [5:0]  funct,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [15:0] imm16,
   output logic [31:0] pc,
   output logic [31:0] retired,
   output state_e      dbg_state_o
);

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic [31:0] retired_q;
   logic [31:0] pc_d;

   npc u_npc (
      .pc      (pc_q),
      .imm16   (instr_q[15:0]),
      .nPC_sel (nPC_sel),
      .zero    (zero),
      .next_pc (pc_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= FETCH;
         pc_q      <= PC_RESET;
         instr_q   <= '0;
         retired_q <= '0;
      end else begin
         case (state_q)
            FETCH: begin
               if (imem_ack) begin
                  instr_q <= imem_rdata;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               if (exec_done) begin
                  pc_q      <= pc_d;
                  retired_q <= retired_q + 32'd1;
                  state_q   <= FETCH;
               end
            end
            default: state_q <= FETCH;
         endcase
      end
   end

   // Gated by reset so the bus is quiet for the whole reset cycle, before the
   // state register itself has been cleared.
   assign imem_req    = (state_q == FETCH) && !reset;
   assign instr_valid = (state_q == ISSUE) && !reset;
   assign imem_addr   = pc_q;

   assign instr   = instr_q;
   assign opcode  = instr_q[31:26];
   assign rs      = instr_q[25:21];
   assign rt      = instr_q[20:16];
   assign rd      = instr_q[15:11];
   assign funct   = instr_q[5:0];
   assign imm16   = instr_q[15:0];
   assign pc      = pc_q;
   assign retired = retired_q;

   assign dbg_state_o = state_q;

endmodule
